wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback-stage sink for the MEM/WB pipeline register: a 32×32 general-purpose register file plus the HI/LO register pair. It consumes the writeback bundle (`wb_wd`, `wb_wreg`, `wb_wdata`, `wb_hi`, `wb_lo`, `wb_whilo`) and commits it at the clock edge. It serves two combinational GPR read ports and a HI/LO read port to the ID/EX stages. Optional same-cycle write-to-read forwarding closes the WB→ID hazard.

## Interface
Parameters:
- `REG_NUM`, 32: number of GPRs. Fixed at 32 for MIPS32; the address width is log2(`REG_NUM`).
- `DATA_W`, 32: register and data width.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `wb_wd`  in  5  GPR write address.
- `wb_wreg`  in  1  GPR write enable.
- `wb_wdata`  in  32  GPR write data.
- `wb_hi`  in  32  HI write data.
- `wb_lo`  in  32  LO write data.
- `wb_whilo`  in  1  HI/LO write enable; writes both HI and LO together.
- `re1`  in  1  read-port-1 enable.
- `raddr1`  in  5  read-port-1 address.
- `rdata1`  out  32  read-port-1 data.
- `re2`  in  1  read-port-2 enable.
- `raddr2`  in  5  read-port-2 address.
- `rdata2`  out  32  read-port-2 data.
- `hi_o`  out  32  current HI value.
- `lo_o`  out  32  current LO value.

## Operation
- **GPR write:** on posedge `clk`, when `rst` is high, `wb_wreg` = 1 and `wb_wd` ≠ 0, `regs[wb_wd] <= wb_wdata`.
  - Writes to `$0` are silently dropped.
  - `$0` always reads 0.
- **HI/LO write:** on posedge `clk`, when `wb_whilo` = 1, `hi <= wb_hi` and `lo <= wb_lo`.
- **GPR read (each port independent, combinational):**
  - `rst` low → 0.
  - `re` = 0 → 0.
  - `raddr` = 0 → 0.
  - Otherwise: forwarded value if applicable (see Configuration), else `regs[raddr]`.
- **HI/LO read:**
  - `rst` low → 0.
  - Otherwise: forwarded value if applicable, else the stored `hi`/`lo`.
- Both read ports may address the same register, and both may match the write address; each resolves independently.
- GPR and HI/LO writes in the same cycle are independent and both commit.

## Timing
- **Reset values:**
  - `rst` low asynchronously clears all 32 GPRs, `hi` and `lo` to 0.
  - While `rst` is low, `rdata1`, `rdata2`, `hi_o` and `lo_o` are all 0.
- **Reset wins over writes:** reset asserted in the same cycle as a write → the write is lost and the register is 0.
- **Release:** first write is accepted at the first rising edge with `rst` high.
- **Write latency:** a value is stored at the edge ending the cycle in which it is presented.
- **Read latency:** 0 cycles; reads are combinational from the address and the forwarding inputs.
- **No handshake:** every presented write is taken unconditionally; stalls are handled upstream by holding the MEM/WB bundle invalid.

## Configuration
- `WB_BYPASS_EN` defined:
  - A read port returns `wb_wdata` when `re` = 1, `raddr` = `wb_wd`, `wb_wreg` = 1 and `raddr` ≠ 0.
  - `hi_o`/`lo_o` return `wb_hi`/`wb_lo` when `wb_whilo` = 1.
  - New data is therefore visible in the same cycle it is written.
- `WB_BYPASS_EN` undefined:
  - Reads return stored state only.
  - A write becomes visible in the cycle after its commit edge; the pipeline must insert a bubble or handle the hazard elsewhere.

## Structure
- **Shared defines:**
  - `RegAddrBus`, `RegBus`, `ZeroWord`, `NOPRegAddr`.
  - `WriteEnable`/`WriteDisable`, `ReadEnable`/`ReadDisable`, `RstEnable` (= 1'b0 for this block).
- **Sub-module `wb_hilo_reg`:** holds HI/LO storage and its bypass. It is instantiated once; the GPR array and read muxing stay in `wb_regfile`.

## Test plan
- **Reset:** write `$5` = 0x1234 and HI = 0xAA, then pulse `rst` low mid-cycle → `rdata1`/`hi_o` read 0 immediately and after release `$5` reads 0.
- **Write/read:** write `$3` = 0xDEADBEEF, then next cycle `raddr1` = 3, `re1` = 1 → 0xDEADBEEF; with `re1` = 0 → 0.
- **`$0` protection:** `wb_wd` = 0, `wb_wreg` = 1, `wb_wdata` = 0xFFFFFFFF → `raddr2` = 0 reads 0 with and without bypass.
- **Forwarding:** `raddr1` = `raddr2` = 7 during a write of 0x55 to `$7` (old value 0x11) → with `WB_BYPASS_EN` both ports read 0x55 in the same cycle; without it, 0x11 that cycle and 0x55 the next.
- **HI/LO:** `wb_whilo` = 1, `wb_hi` = 0x1, `wb_lo` = 0x2, together with a GPR write of `$9` = 0x3 → all three committed; `hi_o`/`lo_o` follow the bypass rule.
- **Back-to-back:** write `$4` = 1, 2, 3 on consecutive edges → reads track 1, 2, 3 with no lost write.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared types and constants for the writeback register file.
// Optional same-cycle forwarding is enabled by defining WB_BYPASS_EN.
package wb_regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;

    typedef logic [REG_ADDR_W-1:0] RegAddrBus;
    typedef logic [REG_W-1:0]      RegBus;

    localparam RegBus     ZeroWord     = '0;
    localparam RegAddrBus NOPRegAddr   = '0;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;
    // This block resets on a low level.
    localparam logic RstEnable    = 1'b0;

endpackage

// File: rtl/wb_hilo_reg.sv
// HI/LO register pair with optional same-cycle bypass of the writeback values.
// Bypass is compiled in when WB_BYPASS_EN is defined.
module wb_hilo_reg
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              wb_whilo,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            hi <= '0;
            lo <= '0;
        end else if (wb_whilo == WriteEnable) begin
            hi <= wb_hi;
            lo <= wb_lo;
        end
    end

    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (rst == RstEnable) begin
            hi_o = '0;
            lo_o = '0;
        end
`ifdef WB_BYPASS_EN
        else if (wb_whilo == WriteEnable) begin
            hi_o = wb_hi;
            lo_o = wb_lo;
        end
`endif
        else begin
            hi_o = hi;
            lo_o = lo;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage GPR file (32 x 32, $0 hardwired to zero) plus HI/LO pair.
// Defining WB_BYPASS_EN forwards the in-flight write to the read ports.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              wb_whilo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] regs [REG_NUM];

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_wreg == WriteEnable && wb_wd != NOPRegAddr) begin
            regs[wb_wd] <= wb_wdata;
        end
    end

    // A non-zero read address matching wb_wd implies wb_wd is non-zero too.
    always_comb begin
        rdata1 = ZeroWord;
        if (rst == RstEnable || re1 == ReadDisable || raddr1 == NOPRegAddr) begin
            rdata1 = ZeroWord;
        end
`ifdef WB_BYPASS_EN
        else if (wb_wreg == WriteEnable && raddr1 == wb_wd) begin
            rdata1 = wb_wdata;
        end
`endif
        else begin
            rdata1 = regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = ZeroWord;
        if (rst == RstEnable || re2 == ReadDisable || raddr2 == NOPRegAddr) begin
            rdata2 = ZeroWord;
        end
`ifdef WB_BYPASS_EN
        else if (wb_wreg == WriteEnable && raddr2 == wb_wd) begin
            rdata2 = wb_wdata;
        end
`endif
        else begin
            rdata2 = regs[raddr2];
        end
    end

    wb_hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk      (clk),
        .rst      (rst),
        .wb_hi    (wb_hi),
        .wb_lo    (wb_lo),
        .wb_whilo (wb_whilo),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expectations adapt to WB_BYPASS_EN.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    wb_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .wb_wd    (wb_wd),
        .wb_wreg  (wb_wreg),
        .wb_wdata (wb_wdata),
        .wb_hi    (wb_hi),
        .wb_lo    (wb_lo),
        .wb_whilo (wb_whilo),
        .re1      (re1),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .re2      (re2),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_writes();
        wb_wreg  = 1'b0;
        wb_wd    = 5'd0;
        wb_wdata = 32'h0;
        wb_whilo = 1'b0;
        wb_hi    = 32'h0;
        wb_lo    = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_writes();
        re1 = 1'b1; raddr1 = 5'd5;
        re2 = 1'b1; raddr2 = 5'd5;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdata1=%h rdata2=%h hi=%h lo=%h expected all 0",
                     rdata1, rdata2, hi_o, lo_o);
        end
        @(negedge clk);
        rst = 1'b1;
        wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'h1234;
        wb_whilo = 1'b1; wb_hi = 32'hAA; wb_lo = 32'hBB;
        @(negedge clk);
        idle_writes();
        #1;
        checks++;
        if (rdata1 !== 32'h1234 || hi_o !== 32'hAA) begin
            errors++;
            $display("FAIL reset_prewrite: rdata1=%h hi=%h expected 00001234/000000aa", rdata1, hi_o);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_midcycle: rdata1=%h hi=%h lo=%h expected 0", rdata1, hi_o, lo_o);
        end
        // Write presented while reset is held across the edge must be lost.
        @(negedge clk);
        wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'h77;
        wb_whilo = 1'b1; wb_hi = 32'h99; wb_lo = 32'h98;
        @(negedge clk);
        idle_writes();
        rst = 1'b1;
        #1;
        checks++;
        if (rdata1 !== 32'h0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_after_release: rdata1=%h hi=%h lo=%h expected 0", rdata1, hi_o, lo_o);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'hDEADBEEF;
        re1 = 1'b1; raddr1 = 5'd3;
        re2 = 1'b1; raddr2 = 5'd3;
        @(negedge clk);
        idle_writes();
        #1;
        checks++;
        if (rdata1 !== 32'hDEADBEEF || rdata2 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_read: rdata1=%h rdata2=%h expected deadbeef", rdata1, rdata2);
        end
        re1 = 1'b0;
        #1;
        checks++;
        if (rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL read_disabled: rdata1=%h expected 0", rdata1);
        end
        raddr2 = 5'd2;
        #1;
        checks++;
        if (rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL read_unwritten: rdata2=%h expected 0", rdata2);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hFFFFFFFF;
        re2 = 1'b1; raddr2 = 5'd0;
        #1;
        checks++;
        if (rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL zero_same_cycle: rdata2=%h expected 0", rdata2);
        end
        @(negedge clk);
        idle_writes();
        #1;
        checks++;
        if (rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL zero_after_write: rdata2=%h expected 0", rdata2);
        end
    endtask

    task automatic test_forward();
        logic [31:0] exp_now;
        @(negedge clk);
        wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'h11;
        @(negedge clk);
        wb_wdata = 32'h55;
        re1 = 1'b1; raddr1 = 5'd7;
        re2 = 1'b1; raddr2 = 5'd7;
        exp_now = BYP ? 32'h55 : 32'h11;
        #1;
        checks++;
        if (rdata1 !== exp_now || rdata2 !== exp_now) begin
            errors++;
            $display("FAIL forward_same_cycle: rdata1=%h rdata2=%h expected %h", rdata1, rdata2, exp_now);
        end
        // Non-matching address must not be forwarded.
        raddr2 = 5'd3;
        #1;
        checks++;
        if (rdata2 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL forward_other_addr: rdata2=%h expected deadbeef", rdata2);
        end
        raddr2 = 5'd7;
        @(negedge clk);
        idle_writes();
        #1;
        checks++;
        if (rdata1 !== 32'h55 || rdata2 !== 32'h55) begin
            errors++;
            $display("FAIL forward_next_cycle: rdata1=%h rdata2=%h expected 00000055", rdata1, rdata2);
        end
    endtask

    task automatic test_hilo();
        logic [31:0] exp_hi, exp_lo, exp_r;
        @(negedge clk);
        wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
        wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'h3;
        re1 = 1'b1; raddr1 = 5'd9;
        exp_hi = BYP ? 32'h1 : 32'h0;
        exp_lo = BYP ? 32'h2 : 32'h0;
        exp_r  = BYP ? 32'h3 : 32'h0;
        #1;
        checks++;
        if (hi_o !== exp_hi || lo_o !== exp_lo || rdata1 !== exp_r) begin
            errors++;
            $display("FAIL hilo_same_cycle: hi=%h lo=%h rdata1=%h expected %h %h %h",
                     hi_o, lo_o, rdata1, exp_hi, exp_lo, exp_r);
        end
        @(negedge clk);
        idle_writes();
        wb_hi = 32'hCAFE; wb_lo = 32'hF00D;
        #1;
        checks++;
        if (hi_o !== 32'h1 || lo_o !== 32'h2 || rdata1 !== 32'h3) begin
            errors++;
            $display("FAIL hilo_commit: hi=%h lo=%h rdata1=%h expected 1 2 3", hi_o, lo_o, rdata1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (hi_o !== 32'h1 || lo_o !== 32'h2) begin
            errors++;
            $display("FAIL hilo_hold: hi=%h lo=%h expected 1 2", hi_o, lo_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        logic [31:0] exp_v;
        prev = 32'h0;
        re1 = 1'b1; raddr1 = 5'd4;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            wb_wreg = 1'b1; wb_wd = 5'd4; wb_wdata = 32'(k);
            exp_v = BYP ? 32'(k) : prev;
            #1;
            checks++;
            if (rdata1 !== exp_v) begin
                errors++;
                $display("FAIL back_to_back_%0d: rdata1=%h expected %h", k, rdata1, exp_v);
            end
            prev = 32'(k);
        end
        @(negedge clk);
        idle_writes();
        #1;
        checks++;
        if (rdata1 !== 32'h3) begin
            errors++;
            $display("FAIL back_to_back_final: rdata1=%h expected 00000003", rdata1);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_forward();
        test_hilo();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
